register_file: RTL

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file_pkg.sv | 35 +++
 rtl/register_file_soft_rst.sv | 34 +++
 rtl/register_file.sv | 130 +++++++++++++
 3 files changed

// File: rtl/register_file_pkg.sv
// Shared command-word layout and opcode map for the MicroBlaze <-> DSP register file.
package register_file_pkg;

    localparam int CMD_W   = 32;
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 24;
    localparam int STB_BIT = 23;
    localparam int DATA_W  = 23;

    typedef enum logic [7:0] {
        OP_NOP       = 8'h00,
        OP_SOFT_RST  = 8'h01,
        OP_TX_EN     = 8'h02,
        OP_RX_EN     = 8'h03,
        OP_PHASE     = 8'h04,
        OP_BER_LATCH = 8'h05,
        OP_RD_ERR_LO = 8'h06,
        OP_RD_ERR_HI = 8'h07,
        OP_RD_BIT_LO = 8'h08,
        OP_RD_BIT_HI = 8'h09,
        OP_LOG_START = 8'h0A,
        OP_RD_STATUS = 8'h0B
    } opcode_e;

    typedef struct packed {
        logic [OPC_MSB-OPC_LSB:0] op;
        logic                     strobe;
        logic [DATA_W-1:0]        data;
    } cmd_t;

    function automatic logic is_read(input opcode_e op);
        return op inside {OP_RD_ERR_LO, OP_RD_ERR_HI, OP_RD_BIT_LO, OP_RD_BIT_HI, OP_RD_STATUS};
    endfunction

endpackage

// File: rtl/register_file_soft_rst.sv
// Counter-based stretcher: one start request yields an active-low pulse of CYCLES clocks.
module soft_rst_gen #(
    parameter int CYCLES = 16
)(
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic soft_rst_n,
    output logic done
);

    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            soft_rst_n <= 1'b1;
            cnt        <= '0;
        end else if (start && soft_rst_n) begin
            soft_rst_n <= 1'b0;
            cnt        <= CW'(CYCLES - 1);
        end else if (!soft_rst_n) begin
            if (cnt == '0)
                soft_rst_n <= 1'b1;
            else
                cnt <= cnt - 1'b1;
        end
    end

    // High on the last low clock, so the owner FSM leaves SRST as the pulse ends.
    assign done = !soft_rst_n && (cnt == '0);

endmodule

// File: rtl/register_file.sv
// GPIO command decoder: strobe-edge commands from MicroBlaze drive DSP controls and BER read-back.
module register_file
    import register_file_pkg::*;
#(
    parameter int NB_GPIOS        = 32,
    parameter int NB_COUNTER      = 64,
    parameter int NB_PHASE        = 2,
    parameter int SOFT_RST_CYCLES = 16
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NB_GPIOS-1:0]   i_gpo,
    output logic [NB_GPIOS-1:0]   o_gpi,
    input  logic [NB_COUNTER-1:0] i_err_cnt,
    input  logic [NB_COUNTER-1:0] i_bit_cnt,
    input  logic                  i_log_full,
    output logic                  o_tx_en,
    output logic                  o_rx_en,
    output logic [NB_PHASE-1:0]   o_phase,
    output logic                  o_log_start,
    output logic                  o_soft_rst_n
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SRST = 1'b1;

    cmd_t                  gpo_q;
    logic [1:0]            vld_pipe;
    logic                  stb_prev;
    opcode_e               cmd_op;
    logic [DATA_W-1:0]     cmd_data;
    logic [0:0]            state;
    logic                  exec;
    logic                  srst_start;
    logic                  srst_done;
    logic [NB_COUNTER-1:0] err_snap;
    logic [NB_COUNTER-1:0] bit_snap;
    logic [63:0]           err_w;
    logic [63:0]           bit_w;
    logic [NB_GPIOS-1:0]   rd_data;
    logic                  unused_data;

    // vld_pipe[0] marks gpo_q as a real sample (not the reset value), so a strobe
    // already high at reset release reads as "previously high" and never fires.
    always_ff @(posedge clk) begin
        if (!rst) begin
            gpo_q    <= '0;
            vld_pipe <= '0;
            stb_prev <= 1'b1;
            cmd_op   <= OP_NOP;
            cmd_data <= '0;
        end else begin
            gpo_q       <= cmd_t'(i_gpo[CMD_W-1:0]);
            vld_pipe[0] <= 1'b1;
            stb_prev    <= gpo_q.strobe | ~vld_pipe[0];
            vld_pipe[1] <= vld_pipe[0] & gpo_q.strobe & ~stb_prev;
            cmd_op      <= opcode_e'(gpo_q.op);
            cmd_data    <= gpo_q.data;
        end
    end

    assign exec        = vld_pipe[1] && (state == ST_IDLE);
    assign srst_start  = exec && (cmd_op == OP_SOFT_RST);
    assign err_w       = 64'(err_snap);
    assign bit_w       = 64'(bit_snap);
    assign unused_data = ^cmd_data;

    always_comb begin
        rd_data = '0;
        case (cmd_op)
            OP_RD_ERR_LO: rd_data = NB_GPIOS'(err_w[31:0]);
            OP_RD_ERR_HI: rd_data = NB_GPIOS'(err_w[63:32]);
            OP_RD_BIT_LO: rd_data = NB_GPIOS'(bit_w[31:0]);
            OP_RD_BIT_HI: rd_data = NB_GPIOS'(bit_w[63:32]);
            OP_RD_STATUS: rd_data = NB_GPIOS'(i_log_full);
            default:      rd_data = '0;
        endcase
    end

    // Commands landing while in SRST are simply dropped; edge tracking above keeps running.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_IDLE;
            o_gpi       <= '0;
            o_tx_en     <= 1'b0;
            o_rx_en     <= 1'b0;
            o_phase     <= '0;
            o_log_start <= 1'b0;
            err_snap    <= '0;
            bit_snap    <= '0;
        end else begin
            o_log_start <= 1'b0;
            if (state == ST_SRST) begin
                if (srst_done)
                    state <= ST_IDLE;
            end else if (exec) begin
                if (is_read(cmd_op))
                    o_gpi <= rd_data;
                case (cmd_op)
                    OP_SOFT_RST: begin
                        state   <= ST_SRST;
                        o_tx_en <= 1'b0;
                        o_rx_en <= 1'b0;
                        o_phase <= '0;
                    end
                    OP_TX_EN:     o_tx_en <= cmd_data[0];
                    OP_RX_EN:     o_rx_en <= cmd_data[0];
                    OP_PHASE:     o_phase <= cmd_data[NB_PHASE-1:0];
                    OP_BER_LATCH: begin
                        err_snap <= i_err_cnt;
                        bit_snap <= i_bit_cnt;
                    end
                    OP_LOG_START: o_log_start <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    soft_rst_gen #(
        .CYCLES(SOFT_RST_CYCLES)
    ) u_soft_rst (
        .clk        (clk),
        .rst        (rst),
        .start      (srst_start),
        .soft_rst_n (o_soft_rst_n),
        .done       (srst_done)
    );

endmodule
